// File: rtl/sabr_sdiv_iter.sv
// ---------------------------------------------------------------------------
// sabr_sdiv_iter -- iterative signed integer divider (radix-2, non-restoring)
//
// Undoes a 13s x 71s scaling in the SABR datapath: divides a signed
// DIVIDEND_WIDTH-bit dividend by a signed DIVISOR_WIDTH-bit divisor, one
// quotient bit per enabled clock, with a latency that does not depend on the
// operand values.
//
// Handshake: a transfer happens on a rising edge where ce=1 and both valid and
// ready are high. in_valid/in_ready accept an operand pair (in_ready is high
// only in IDLE); out_valid/out_ready hand over the result, which stays stable
// until that handshake edge. One operation is in flight at a time.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   ce           clock enable; when low all state holds, no handshake completes
//   din0         signed dividend                     (DIVIDEND_WIDTH)
//   din1         signed divisor                      (DIVISOR_WIDTH)
//   in_valid     operands valid
//   in_ready     divider idle, operands will be accepted
//   dout_q       signed quotient                     (DIVIDEND_WIDTH)
//   dout_r       signed remainder, sign of dividend  (DIVISOR_WIDTH)
//   div_by_zero  divisor was zero (quotient saturated by dividend sign)
//   ovf          quotient saturated to +max
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   dbg_state_o  current FSM state, for observation only
//
// Build option: define SABR_SDIV_ROUND_EN to round the quotient half away
// from zero (adds a ROUND state, +1 cycle latency); dout_r then matches the
// rounded quotient. Undefined: truncation toward zero.
// ---------------------------------------------------------------------------
module sabr_sdiv_iter #(
  parameter int DIVIDEND_WIDTH = 71,
  parameter int DIVISOR_WIDTH  = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DIVIDEND_WIDTH-1:0] dout_q,
  output logic [DIVISOR_WIDTH-1:0]  dout_r,
  output logic                      div_by_zero,
  output logic                      ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                dbg_state_o
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int RW = VW + 1;               // partial remainder width
  localparam int CW = $clog2(DW);

  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [DW-1:0] Q_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN    = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_SIGN  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   quo_q;     // dividend magnitude shifting out, quotient shifting in
  logic [RW-1:0]   rem_q;     // two's complement partial remainder
  logic [VW-1:0]   dmag_q;
  logic            sign0_q;
  logic            sign1_q;

  logic [DW-1:0]   a_mag;
  logic [VW-1:0]   d_mag;
  logic [RW-1:0]   dext;
  logic [RW-1:0]   rem_shift;
  logic [RW-1:0]   rem_step;
  logic [RW-1:0]   rem_next;
  logic            q_bit;
  logic            q_neg;
  logic [VW-1:0]   r_mag;

  assign in_ready    = (state_q == S_IDLE);
  assign dbg_state_o = state_q;

  // Magnitudes; the most negative dividend maps to 2^(DW-1), still exact
  // as an unsigned DW-bit value.
  assign a_mag = din0[DW-1] ? (~din0 + DW'(1)) : din0;
  assign d_mag = din1[VW-1] ? (~din1 + VW'(1)) : din1;

  // One non-restoring step: the partial remainder stays within [-D, D), so
  // 2R+bit fits RW bits and the old sign bit can be dropped in the shift.
  assign dext      = {1'b0, dmag_q};
  assign rem_shift = {rem_q[RW-2:0], quo_q[DW-1]};
  assign rem_step  = rem_q[RW-1] ? (rem_shift + dext) : (rem_shift - dext);
  assign q_bit     = ~rem_step[RW-1];
  // Final remainder correction folded into the last iteration.
  assign rem_next  = ((cnt_q == '0) && rem_step[RW-1]) ? (rem_step + dext) : rem_step;

  assign q_neg = sign0_q ^ sign1_q;
  assign r_mag = rem_q[VW-1:0];

`ifdef SABR_SDIV_ROUND_EN
  logic          do_round;
  logic [VW-1:0] r_rnd_mag;
  // Round when 2|r| >= |d|; the flagged cases keep their saturated result.
  assign do_round  = ({r_mag, 1'b0} >= {1'b0, dmag_q}) && !div_by_zero && !ovf;
  // Stepping the quotient magnitude up by one leaves |r'| = |d| - |r| with
  // the opposite sign to the dividend.
  assign r_rnd_mag = dmag_q - r_mag;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dmag_q      <= '0;
      sign0_q     <= 1'b0;
      sign1_q     <= 1'b0;
      dout_q      <= '0;
      dout_r      <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
      out_valid   <= 1'b0;
    end else if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            quo_q   <= a_mag;
            dmag_q  <= d_mag;
            sign0_q <= din0[DW-1];
            sign1_q <= din1[VW-1];
            rem_q   <= '0;
            cnt_q   <= CNT_LAST;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          quo_q <= {quo_q[DW-2:0], q_bit};
          rem_q <= rem_next;
          if (cnt_q == '0) begin
            state_q <= S_SIGN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_SIGN: begin
          if (dmag_q == '0) begin
            dout_q      <= sign0_q ? Q_MIN : Q_MAX;
            dout_r      <= '0;
            div_by_zero <= 1'b1;
            ovf         <= 1'b0;
          end else if (!q_neg && quo_q[DW-1]) begin
            // Only the most negative dividend over -1 reaches 2^(DW-1).
            dout_q      <= Q_MAX;
            dout_r      <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b1;
          end else begin
            dout_q      <= q_neg ? (~quo_q + DW'(1)) : quo_q;
            dout_r      <= sign0_q ? (~r_mag + VW'(1)) : r_mag;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
          end
`ifdef SABR_SDIV_ROUND_EN
          state_q <= S_ROUND;
`else
          out_valid <= 1'b1;
          state_q   <= S_DONE;
`endif
        end
`ifdef SABR_SDIV_ROUND_EN
        S_ROUND: begin
          if (do_round) begin
            if (q_neg) begin
              dout_q <= dout_q - DW'(1);
              dout_r <= sign0_q ? r_rnd_mag : (~r_rnd_mag + VW'(1));
            end else if (dout_q == Q_MAX) begin
              ovf <= 1'b1;
            end else begin
              dout_q <= dout_q + DW'(1);
              dout_r <= sign0_q ? r_rnd_mag : (~r_rnd_mag + VW'(1));
            end
          end
          out_valid <= 1'b1;
          state_q   <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
